tc_meas_sched: RTL and testbench

Measurement scheduler for the theremin antenna front end. It time-shares one `tc_meas` time-constant counter between the pitch antenna and the volume antenna. For each measurement it selects an antenna, toggles that antenna's excitation pin and waits for the measured count. It averages 2^AVG_LOG2 counts per antenna and publishes one averaged result per antenna, alternating pitch, volume, pitch, and so on.

---
 rtl/tc_pkg.sv | 22 ++
 rtl/tc_sched_accum.sv | 54 +++++
 rtl/tc_meas_sched.sv | 185 ++++++++++++++++++
 tb/tb_tc_meas_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared types and constants for the theremin time-constant measurement scheduler.
package tc_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StExcite,
    StWait
  } tc_sched_state_t;

  // Antenna channel numbers; also the bit index into ant_drive
  localparam logic CH_PITCH = 1'b0;
  localparam logic CH_VOL   = 1'b1;

  // Accumulator width: 2^avg_log2 samples of d_bits each can never overflow it
  function automatic int unsigned acc_width(input int unsigned d_bits,
                                            input int unsigned avg_log2);
    return d_bits + avg_log2;
  endfunction

endpackage

// File: rtl/tc_sched_accum.sv
// Sample accumulator for tc_meas_sched: sums 2^AVG_LOG2 samples and reports the
// truncated average in the same cycle the final sample is added.
module tc_sched_accum
  import tc_pkg::*;
#(
  parameter int unsigned D_BITS   = 12,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              add,
  input  logic [D_BITS-1:0] sample,
  input  logic              clear,
  output logic              done,
  output logic [D_BITS-1:0] avg
);

  localparam int unsigned AccW = acc_width(D_BITS, AVG_LOG2);
  localparam int unsigned CntW = AVG_LOG2 + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0] acc_q, acc_d, sum;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign sum  = acc_q + AccW'(sample);
  // done is combinational so the top can latch avg together with the accepting sample
  assign done = add && (cnt_q == LastCnt);
  assign avg  = D_BITS'(sum >> AVG_LOG2);

  // Next accumulator/count: restart after a completed average or on clear
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear || done) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add) begin
      acc_d = sum;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Accumulator and sample counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tc_meas_sched.sv
// Measurement scheduler: time-shares one tc_meas counter between the pitch and
// volume antennas, averages 2^AVG_LOG2 counts per antenna and publishes results
// alternately for pitch and volume.
// Optional feature: define TC_SCHED_TIMEOUT_EN to enable the WAIT timeout and
// err_timeout; otherwise WAIT waits indefinitely and err_timeout is tied low.
module tc_meas_sched
  import tc_pkg::*;
#(
  parameter int unsigned D_BITS      = 12,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned SETTLE_CYC  = 256,
  parameter int unsigned TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [D_BITS-1:0] meas_data,
  input  logic              meas_valid,
  output logic [1:0]        ant_drive,
  output logic              meas_excite,
  output logic              meas_sel,
  output logic [D_BITS-1:0] res_data,
  output logic              res_ch,
  output logic              res_valid,
  output logic              err_timeout,
  output logic              busy
);

  localparam int unsigned TmrMax = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam logic [TmrW-1:0] SettleLast = TmrW'(SETTLE_CYC - 1);
`ifdef TC_SCHED_TIMEOUT_EN
  localparam logic [TmrW-1:0] TimeoutLast = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [D_BITS-1:0] SatSample = '1;
`endif

  tc_sched_state_t state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            ch_q, ch_d, ch_next;
  logic [1:0]      drive_q, drive_d;
  logic            excite_q;
  logic [D_BITS-1:0] res_data_q;
  logic            res_ch_q;
  logic            res_valid_q;

  logic              acc_add;
  logic              acc_clear;
  logic [D_BITS-1:0] acc_sample;
  logic              acc_done;
  logic [D_BITS-1:0] acc_avg;

`ifdef TC_SCHED_TIMEOUT_EN
  logic tmo;
  logic err_q;
`endif

  tc_sched_accum #(
    .D_BITS   (D_BITS),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .add     (acc_add),
    .sample  (acc_sample),
    .clear   (acc_clear),
    .done    (acc_done),
    .avg     (acc_avg)
  );

  // Next-state, timer, channel and pin-drive decisions
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    ch_d       = ch_q;
    drive_d    = drive_q;
    acc_add    = 1'b0;
    acc_clear  = 1'b0;
    acc_sample = meas_data;
`ifdef TC_SCHED_TIMEOUT_EN
    tmo        = 1'b0;
`endif
    if ((state_q != StIdle) && !enable) begin
      // Abort: drop the partial average, pins keep their level
      state_d   = StIdle;
      tmr_d     = '0;
      acc_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            ch_d      = CH_PITCH;
            tmr_d     = '0;
            acc_clear = 1'b1;
            state_d   = StSettle;
          end
        end
        StSettle: begin
          if (tmr_q == SettleLast) begin
            tmr_d   = '0;
            state_d = StExcite;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        StExcite: begin
          drive_d[ch_q] = ~drive_q[ch_q];
          tmr_d         = '0;
          state_d       = StWait;
        end
        StWait: begin
          if (meas_valid) begin
            acc_add = 1'b1;
            tmr_d   = '0;
            state_d = StSettle;
`ifdef TC_SCHED_TIMEOUT_EN
          end else if (tmr_q == TimeoutLast) begin
            // Missing edge counts as a full-scale sample
            acc_add    = 1'b1;
            acc_sample = SatSample;
            tmo        = 1'b1;
            tmr_d      = '0;
            state_d    = StSettle;
          end else begin
            tmr_d = tmr_q + 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Channel flips once its average is complete; kept outside the FSM block so
  // the accumulator's done path does not loop back into the block that drives add
  assign ch_next = ch_d ^ acc_done;

  // State, timer, pin and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      ch_q        <= CH_PITCH;
      drive_q     <= 2'b00;
      excite_q    <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= CH_PITCH;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ch_q        <= ch_next;
      drive_q     <= drive_d;
      // Track the pin of whichever antenna is selected next cycle
      excite_q    <= drive_d[ch_next];
      res_valid_q <= acc_done;
      if (acc_done) begin
        res_data_q <= acc_avg;
        res_ch_q   <= ch_q;
      end
    end
  end

`ifdef TC_SCHED_TIMEOUT_EN
  // One-cycle timeout strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= tmo;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign ant_drive   = drive_q;
  assign meas_excite = excite_q;
  assign meas_sel    = ch_q;
  assign res_data    = res_data_q;
  assign res_ch      = res_ch_q;
  assign res_valid   = res_valid_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_tc_meas_sched.sv
// Scoreboard bench for tc_meas_sched: a model average is queued whenever the
// bench completes a group of samples and popped when res_valid appears.
module tb_tc_meas_sched;

  localparam int unsigned DBits      = 12;
  localparam int unsigned AvgLog2    = 2;
  localparam int unsigned SettleCyc  = 8;
  localparam int unsigned TimeoutCyc = 64;
  localparam int unsigned NAvg       = 1 << AvgLog2;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic             enable     = 1'b0;
  logic             meas_valid = 1'b0;
  logic [DBits-1:0] meas_data  = '0;
  logic [1:0]       ant_drive;
  logic             meas_excite;
  logic             meas_sel;
  logic [DBits-1:0] res_data;
  logic             res_ch;
  logic             res_valid;
  logic             err_timeout;
  logic             busy;

  int n_asserts = 0;
  int n_fail    = 0;

  int         model_acc = 0;
  int         model_n   = 0;
  logic       model_ch  = 1'b0;
  logic [12:0] exp_q[$];

  int         tog0 = 0;
  int         tog1 = 0;
  int         n_err = 0;
  logic [1:0] last_drive = 2'b00;

  tc_meas_sched #(
    .D_BITS      (DBits),
    .AVG_LOG2    (AvgLog2),
    .SETTLE_CYC  (SettleCyc),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .meas_data   (meas_data),
    .meas_valid  (meas_valid),
    .ant_drive   (ant_drive),
    .meas_excite (meas_excite),
    .meas_sel    (meas_sel),
    .res_data    (res_data),
    .res_ch      (res_ch),
    .res_valid   (res_valid),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Output monitor: scoreboard pop, pin-toggle counting, excite/select consistency
  always @(negedge clk) begin
    logic [12:0] e;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("res_unexpected", res_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("res_data", res_data, e[11:0]);
        check_eq("res_ch", res_ch, e[12]);
      end
    end
    if (err_timeout) n_err++;
    if (ant_drive[0] != last_drive[0]) tog0++;
    if (ant_drive[1] != last_drive[1]) tog1++;
    last_drive = ant_drive;
    check_eq("excite_eq_sel", meas_excite, ant_drive[meas_sel]);
  end

  task automatic model_add(input int d);
    model_acc += d;
    model_n++;
    if (model_n == NAvg) begin
      exp_q.push_back({model_ch, 12'(model_acc >> AvgLog2)});
      model_acc = 0;
      model_n   = 0;
      model_ch  = ~model_ch;
    end
  endtask

  task automatic model_reset();
    model_acc = 0;
    model_n   = 0;
    model_ch  = 1'b0;
  endtask

  // Wait for the EXCITE pin toggle; returns at the negedge in the first WAIT cycle
  task automatic wait_excite(output bit ok);
    logic [1:0] prev;
    prev = ant_drive;
    ok   = 1'b0;
    for (int i = 0; i < int'(SettleCyc) + 16; i++) begin
      @(negedge clk);
      if (ant_drive !== prev) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("excite_seen", ok, 1);
  endtask

  task automatic do_sample(input int d, input int delay);
    bit ok;
    wait_excite(ok);
    if (!ok) return;
    check_eq("meas_sel", meas_sel, model_ch);
    repeat (delay) @(negedge clk);
    meas_valid = 1'b1;
    meas_data  = DBits'(d);
    model_add(d);
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  task automatic expect_drained();
    repeat (3) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
  endtask

`ifdef TC_SCHED_TIMEOUT_EN
  task automatic skip_sample();
    bit ok;
    int start;
    int lat;
    wait_excite(ok);
    if (!ok) return;
    check_eq("meas_sel_skip", meas_sel, model_ch);
    model_add(4095);
    start = n_err;
    lat   = -1;
    for (int i = 0; i < int'(TimeoutCyc) + 8; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        lat = i;
        break;
      end
    end
    check_eq("timeout_latency", lat, TimeoutCyc - 1);
    repeat (2) @(negedge clk);
    check_eq("err_pulse_count", n_err - start, 1);
  endtask
`endif

  initial begin
    int err0;
    bit ok;
    logic [1:0] saved;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_ant_drive", ant_drive, 0);
    check_eq("rst_meas_excite", meas_excite, 0);
    check_eq("rst_meas_sel", meas_sel, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_res_ch", res_ch, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_err_timeout", err_timeout, 0);
    check_eq("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // Averaging and pin toggling over 8 measurements
    enable = 1'b1;
    tog0   = 0;
    tog1   = 0;
    @(negedge clk);
    check_eq("run_busy", busy, 1);
    do_sample(100, 1);
    do_sample(101, 0);
    do_sample(102, 2);
    do_sample(103, 1);
    do_sample(4095, 0);
    do_sample(4095, 3);
    do_sample(4095, 1);
    do_sample(4094, 0);
    check_eq("toggles_pitch", tog0, 4);
    check_eq("toggles_volume", tog1, 4);
    repeat (3) @(negedge clk);
    check_eq("res_data_hold", res_data, 4094);
    check_eq("res_ch_hold", res_ch, 1);

    // Truncating average
    do_sample(1, 0);
    do_sample(2, 2);
    do_sample(2, 0);
    do_sample(2, 4);

`ifdef TC_SCHED_TIMEOUT_EN
    // Timeout on one sample (volume channel), then a valid on the expiry cycle
    skip_sample();
    do_sample(0, 0);
    do_sample(0, 1);
    do_sample(0, 0);
    err0 = n_err;
    do_sample(50, TimeoutCyc - 1);
    do_sample(10, 0);
    do_sample(20, 1);
    do_sample(30, 0);
    repeat (2) @(negedge clk);
    check_eq("simul_no_err", n_err - err0, 0);
`else
    // Without the timeout a long WAIT still accepts the sample
    do_sample(7, 100);
    do_sample(8, 0);
    do_sample(9, 1);
    do_sample(10, 0);
    do_sample(4, 0);
    do_sample(4, 2);
    do_sample(4, 0);
    do_sample(4, 1);
    check_eq("no_err_timeout", n_err, 0);
`endif
    expect_drained();

    // Enable drop after two samples (volume channel active)
    do_sample(500, 0);
    do_sample(600, 1);
    enable = 1'b0;
    saved  = ant_drive;
    @(negedge clk);
    check_eq("drop_busy", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("drop_drive_hold", ant_drive, saved);
    check_eq("drop_still_idle", busy, 0);
    model_reset();
    enable = 1'b1;
    do_sample(200, 0);
    do_sample(200, 1);
    do_sample(200, 0);
    do_sample(203, 2);
    expect_drained();

    // Asynchronous reset during WAIT
    wait_excite(ok);
    repeat (2) @(negedge clk);
    check_eq("pre_rst_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst_ant_drive", ant_drive, 0);
    check_eq("arst_meas_excite", meas_excite, 0);
    check_eq("arst_meas_sel", meas_sel, 0);
    check_eq("arst_res_data", res_data, 0);
    check_eq("arst_res_ch", res_ch, 0);
    check_eq("arst_res_valid", res_valid, 0);
    check_eq("arst_err_timeout", err_timeout, 0);
    check_eq("arst_busy", busy, 0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    do_sample(10, 0);
    do_sample(20, 1);
    do_sample(30, 0);
    do_sample(41, 0);
    expect_drained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
